// File: rtl/program_loader.sv
// program_loader: receives a framed instruction image over a valid/ready byte
// stream and writes the payload into byte-wide main memory. The frame is a
// 16-bit big-endian word count N, then 2N payload bytes, then one XOR
// checksum byte. The CPU is held off until a complete image with a good
// checksum has been written.
module program_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int BASE_ADDR  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] byte_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_LENGTH   = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;

  // Memory size in bytes, held wide enough that 2^16 and BASE_ADDR + 2N never wrap.
  localparam logic [17:0] MEM_BYTES = 18'd1 << ADDR_WIDTH;

  logic [2:0]            state;
  logic [7:0]            len_hi;
  logic [16:0]           total_bytes;
  logic [7:0]            xor_acc;
  logic                  transfer;
  logic [15:0]           len_word;
  logic [17:0]           need_bytes;
  logic                  overflow;
  logic [15:0]           count_next;
  logic                  last_byte;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // All status outputs are decoded from the state register, so they change
  // only on clock edges and never depend on the stream inputs.
  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_PAYLOAD) || (state == S_CHECK);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);
  assign cpu_hold = (state != S_DONE);

  assign transfer   = in_valid & in_ready;
  assign len_word   = {len_hi, in_data};
  assign need_bytes = 18'(BASE_ADDR) + {1'b0, len_word, 1'b0};
  assign overflow   = need_bytes > MEM_BYTES;
  assign count_next = byte_count + 16'd1;
  assign last_byte  = ({1'b0, count_next} == total_bytes);
  assign wr_addr    = ADDR_WIDTH'(BASE_ADDR) + byte_count[ADDR_WIDTH-1:0];

  // Frame sequencer: parses the header, issues one registered memory write
  // per accepted payload byte and judges the checksum at the end.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      len_hi      <= 8'h00;
      total_bytes <= 17'd0;
      xor_acc     <= 8'h00;
      byte_count  <= 16'd0;
      err_code    <= ERR_NONE;
      mem_we      <= 1'b0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_LEN_HI;
            xor_acc    <= 8'h00;
            byte_count <= 16'd0;
            err_code   <= ERR_NONE;
          end
        end
        S_LEN_HI: begin
          if (transfer) begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (transfer) begin
            total_bytes <= {len_word, 1'b0};
            if (overflow) begin
              err_code <= ERR_LENGTH;
              state    <= S_ERROR;
            end else if (len_word == 16'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (transfer) begin
            mem_we     <= 1'b1;
            mem_addr   <= 16'(wr_addr);
            mem_wdata  <= {8'h00, in_data};
            byte_count <= count_next;
            xor_acc    <= xor_acc ^ in_data;
            if (last_byte) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (transfer) begin
            if (in_data == xor_acc) begin
              state <= S_DONE;
            end else begin
              err_code <= ERR_CHECKSUM;
              state    <= S_ERROR;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
